// File: rtl/microcode_sequencer_if.sv
// Memory-stage control bus between the microcode sequencer and its environment.
// Carries the opcode/flag inputs, the microcode ROM port and every control strobe.
interface microcode_sequencer_if #(
   parameter int STEP_WIDTH = 4,
   parameter int AUX_WIDTH  = 8
);
   logic [7:0]                  i_instrCode;
   logic [2:0]                  i_flags;
   logic                        i_pause;
   logic [8+STEP_WIDTH-1:0]     o_ucodeAddress;
   logic [16+AUX_WIDTH-1:0]     i_ucodeData;
   logic                        o_ctrlNotPCIncr;
   logic                        o_ctrlNotPCLoad;
   logic                        o_ctrlSpDirection;
   logic                        o_ctrlNotSpEn;
   logic                        o_ctrlInstrNWE;
   logic                        o_ctrlInstrImmNOE;
   logic                        o_ctrlRamNOE;
   logic                        o_ctrlRamNWE;
   logic [AUX_WIDTH-1:0]        o_ctrlAux;
   logic                        o_halted;
   logic [STEP_WIDTH-1:0]       o_step;

   modport master (
      input  i_instrCode, i_flags, i_pause, i_ucodeData,
      output o_ucodeAddress, o_ctrlNotPCIncr, o_ctrlNotPCLoad,
             o_ctrlSpDirection, o_ctrlNotSpEn, o_ctrlInstrNWE,
             o_ctrlInstrImmNOE, o_ctrlRamNOE, o_ctrlRamNWE,
             o_ctrlAux, o_halted, o_step
   );

   modport slave (
      output i_instrCode, i_flags, i_pause, i_ucodeData,
      input  o_ucodeAddress, o_ctrlNotPCIncr, o_ctrlNotPCLoad,
             o_ctrlSpDirection, o_ctrlNotSpEn, o_ctrlInstrNWE,
             o_ctrlInstrImmNOE, o_ctrlRamNOE, o_ctrlRamNWE,
             o_ctrlAux, o_halted, o_step
   );
endinterface

// File: rtl/microcode_sequencer.sv
// Fetch/execute/halt sequencer stepping per-opcode microcode from an async ROM.
// Decodes each microcode word combinationally onto the memory-stage strobes.
module microcode_sequencer #(
   parameter int STEP_WIDTH = 4,
   parameter int AUX_WIDTH  = 8
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   microcode_sequencer_if.master bus
);
   typedef enum logic [1:0] {
      FETCH = 2'd0,
      EXEC  = 2'd1,
      HALT  = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [STEP_WIDTH-1:0]   step_q, step_d;
   logic [2:0]              flags_q, flags_d;

   logic [16+AUX_WIDTH-1:0] w;
   logic                    cond_ok;
   logic                    unused_rsvd;

   logic                    pc_incr, not_pc_load, sp_dir, not_sp_en;
   logic                    instr_nwe, imm_noe, ram_noe, ram_nwe;
   logic [AUX_WIDTH-1:0]    aux;

   assign w           = bus.i_ucodeData;
   assign unused_rsvd = ^w[15:13];

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q <= FETCH;
         step_q  <= '0;
         flags_q <= '0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         flags_q <= flags_d;
      end
   end

   // Flags are {N,Z,C}; cond 00 is unconditional and ignores the invert bit.
   always_comb begin
      cond_ok = 1'b1;
      case (w[8:7])
         2'b01:   cond_ok = flags_q[0] ^ w[9];
         2'b10:   cond_ok = flags_q[1] ^ w[9];
         2'b11:   cond_ok = flags_q[2] ^ w[9];
         default: cond_ok = 1'b1;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      step_d      = step_q;
      flags_d     = flags_q;
      pc_incr     = 1'b0;
      not_pc_load = 1'b1;
      sp_dir      = 1'b0;
      not_sp_en   = 1'b1;
      instr_nwe   = 1'b1;
      imm_noe     = 1'b1;
      ram_noe     = 1'b1;
      ram_nwe     = 1'b1;
      aux         = '0;
      if (!bus.i_pause) begin
         unique case (state_q)
            FETCH: begin
               instr_nwe = 1'b0;
               pc_incr   = 1'b1;
               state_d   = EXEC;
               step_d    = '0;
            end
            EXEC: begin
               pc_incr     = w[0];
               not_pc_load = ~(w[1] & cond_ok);
               not_sp_en   = ~w[2];
               sp_dir      = w[3];
               imm_noe     = ~w[4];
               ram_noe     = ~w[5];
               ram_nwe     = ~w[6];
               aux         = w[16 +: AUX_WIDTH];
               if (w[10])
                  flags_d = bus.i_flags;
               // Halt beats last; a full step counter forces a fetch.
               if (w[12]) begin
                  state_d = HALT;
               end else if (w[11] || (&step_q)) begin
                  state_d = FETCH;
                  step_d  = '0;
               end else begin
                  step_d = step_q + 1'b1;
               end
            end
            HALT: begin
               state_d = HALT;
            end
            default: begin
               state_d = FETCH;
               step_d  = '0;
            end
         endcase
      end
   end

   assign bus.o_ucodeAddress    = {bus.i_instrCode, step_q};
   assign bus.o_step            = step_q;
   assign bus.o_halted          = (state_q == HALT);
   assign bus.o_ctrlNotPCIncr   = pc_incr;
   assign bus.o_ctrlNotPCLoad   = not_pc_load;
   assign bus.o_ctrlSpDirection = sp_dir;
   assign bus.o_ctrlNotSpEn     = not_sp_en;
   assign bus.o_ctrlInstrNWE    = instr_nwe;
   assign bus.o_ctrlInstrImmNOE = imm_noe;
   assign bus.o_ctrlRamNOE      = ram_noe;
   assign bus.o_ctrlRamNWE      = ram_nwe;
   assign bus.o_ctrlAux         = aux;
endmodule

// File: tb/tb_microcode_sequencer.sv
// Scoreboard bench for microcode_sequencer: instruction-level reference model
// pushes expected per-cycle outputs; a negedge monitor pops and compares.
module tb_microcode_sequencer;
   localparam int SW = 4;
   localparam int AW = 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   microcode_sequencer_if #(.STEP_WIDTH(SW), .AUX_WIDTH(AW)) bus ();

   microcode_sequencer #(.STEP_WIDTH(SW), .AUX_WIDTH(AW)) dut (
      .i_clk   (clk),
      .i_reset (rst_n),
      .bus     (bus)
   );

   logic [23:0] rom [256][16];
   assign bus.i_ucodeData =
      rom[bus.o_ucodeAddress[11:4]][bus.o_ucodeAddress[3:0]];

   // strb = {pcIncr, notPcLoad, spDir, notSpEn, instrNWE, immNOE, ramNOE, ramNWE}
   typedef struct packed {
      logic [11:0] addr;
      logic [7:0]  strb;
      logic [7:0]  aux;
      logic        halted;
      logic [3:0]  step;
   } obs_t;

   typedef struct packed {
      obs_t v;
      obs_t m;
   } exp_t;

   exp_t       sbq[$];
   int         vectors = 0;
   int         miscompares = 0;
   logic [2:0] mflags;

   exp_t mon_e;
   obs_t mon_a;

   always @(negedge clk) begin
      if (sbq.size() > 0) begin
         mon_e = sbq.pop_front();
         mon_a.addr   = bus.o_ucodeAddress;
         mon_a.strb   = {bus.o_ctrlNotPCIncr, bus.o_ctrlNotPCLoad,
                         bus.o_ctrlSpDirection, bus.o_ctrlNotSpEn,
                         bus.o_ctrlInstrNWE, bus.o_ctrlInstrImmNOE,
                         bus.o_ctrlRamNOE, bus.o_ctrlRamNWE};
         mon_a.aux    = bus.o_ctrlAux;
         mon_a.halted = bus.o_halted;
         mon_a.step   = bus.o_step;
         vectors++;
         if (((mon_a ^ mon_e.v) & mon_e.m) != '0) begin
            miscompares++;
            $display("FAIL outputs t=%0t actual=%h expected=%h mask=%h",
                     $time, mon_a, mon_e.v, mon_e.m);
         end
      end
   end

   function automatic obs_t idle_v(logic [7:0] op, logic [3:0] s);
      obs_t o;
      o        = '0;
      o.addr   = {op, s};
      o.strb   = 8'b0101_1111;
      o.step   = s;
      return o;
   endfunction

   function automatic obs_t fetch_v(logic [7:0] op);
      obs_t o;
      o      = idle_v(op, 4'd0);
      o.strb = 8'b1101_0111;
      return o;
   endfunction

   function automatic logic cond_true(logic [23:0] w);
      int sel;
      sel = int'(w[8:7]);
      if (sel == 0) return 1'b1;
      return mflags[sel-1] ^ w[9];
   endfunction

   function automatic obs_t exec_v(logic [7:0] op, logic [3:0] s,
                                   logic [23:0] w);
      obs_t o;
      o      = idle_v(op, s);
      o.strb = {w[0], ~(w[1] & cond_true(w)), w[3], ~w[2],
                1'b1, ~w[4], ~w[5], ~w[6]};
      o.aux  = w[23:16];
      return o;
   endfunction

   task automatic put(input obs_t v, input bit mask_step);
      exp_t e;
      e.v = v;
      e.m = '1;
      if (mask_step) begin
         e.m.addr[3:0] = '0;
         e.m.step      = '0;
      end
      sbq.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic pause_cycles(input logic [7:0] op, input logic [3:0] s,
                               input int n);
      for (int i = 0; i < n; i++) begin
         bus.i_pause = 1'b1;
         bus.i_flags = 3'($urandom);
         put(idle_v(op, s), 1'b0);
      end
      bus.i_pause = 1'b0;
   endtask

   task automatic do_reset(input logic [7:0] op);
      rst_n = 1'b0;
      put(fetch_v(op), 1'b0);
      rst_n  = 1'b1;
      mflags = '0;
   endtask

   task automatic run_instr(input logic [7:0] op, input int pstep,
                            input int plen, input bit rst_mid,
                            input bit fl_fix, input logic [2:0] fl_val,
                            output bit halted);
      logic [23:0] w;
      obs_t        v;
      int          np;
      halted = 1'b0;
      bus.i_instrCode = op;
      if ($urandom_range(7) == 0)
         pause_cycles(op, 4'd0, int'($urandom_range(1, 3)));
      bus.i_flags = 3'($urandom);
      put(fetch_v(op), 1'b0);
      for (int s = 0; s < 16; s++) begin
         if (s == pstep) np = plen;
         else if ($urandom_range(9) == 0) np = int'($urandom_range(1, 3));
         else np = 0;
         pause_cycles(op, 4'(s), np);
         if (s == pstep && rst_mid) begin
            // Reset lands mid-cycle while still paused: clear is immediate.
            bus.i_pause = 1'b1;
            rst_n = 1'b0;
            put(idle_v(op, 4'd0), 1'b0);
            bus.i_pause = 1'b0;
            put(fetch_v(op), 1'b0);
            rst_n  = 1'b1;
            mflags = '0;
            return;
         end
         w = rom[op][s];
         bus.i_flags = fl_fix ? fl_val : 3'($urandom);
         v = exec_v(op, 4'(s), w);
         if (w[10]) mflags = bus.i_flags;
         put(v, 1'b0);
         if (w[12]) begin
            halted = 1'b1;
            return;
         end
         if (w[11]) return;
      end
   endtask

   task automatic run_halt(input logic [7:0] op);
      obs_t v;
      v        = idle_v(op, 4'd0);
      v.halted = 1'b1;
      for (int i = 0; i < 20; i++) begin
         bus.i_pause = ($urandom_range(3) == 0);
         bus.i_flags = 3'($urandom);
         put(v, 1'b1);
      end
      bus.i_pause = 1'b0;
      do_reset(op);
   endtask

   initial begin
      bit h;
      logic [23:0] w;
      logic [7:0]  op;
      rst_n           = 1'b0;
      bus.i_pause     = 1'b0;
      bus.i_instrCode = 8'h00;
      bus.i_flags     = 3'b000;
      mflags          = '0;

      for (int o = 0; o < 256; o++) begin
         for (int s = 0; s < 16; s++) begin
            w     = 24'($urandom);
            w[12] = 1'b0;
            w[11] = ($urandom_range(3) == 0);
            rom[o][s] = w;
         end
      end
      rom[8'h12][0] = 24'h000010;
      rom[8'h12][1] = 24'h000040;
      rom[8'h12][2] = 24'h000840;
      for (int s = 0; s < 16; s++)
         rom[8'h20][s] = rom[8'h20][s] & 24'hFFE7FF;
      rom[8'h30][0] = 24'h000400;
      rom[8'h30][1] = 24'h000902;
      rom[8'h31][0] = 24'h000400;
      rom[8'h31][1] = 24'h000B02;
      for (int s = 0; s < 4; s++)
         rom[8'h40][s] = (rom[8'h40][s] & 24'hFFE7FF) | ((s == 3) ? 24'h000800 : 24'h0);
      rom[8'hFF][0] = 24'h5A0021;
      rom[8'hFF][1] = 24'hC31875;

      @(posedge clk);
      #1;
      put(fetch_v(8'h00), 1'b0);
      put(fetch_v(8'h00), 1'b0);
      rst_n = 1'b1;

      run_instr(8'h12, -1, 0, 1'b0, 1'b0, 3'b000, h);
      run_instr(8'h30, -1, 0, 1'b0, 1'b1, 3'b010, h);
      run_instr(8'h30, -1, 0, 1'b0, 1'b1, 3'b000, h);
      run_instr(8'h31, -1, 0, 1'b0, 1'b1, 3'b000, h);
      run_instr(8'h20, -1, 0, 1'b0, 1'b0, 3'b000, h);
      run_instr(8'h40,  2, 5, 1'b0, 1'b0, 3'b000, h);
      run_instr(8'h40,  2, 3, 1'b1, 1'b0, 3'b000, h);
      run_instr(8'h12, -1, 0, 1'b0, 1'b0, 3'b000, h);
      run_instr(8'hFF, -1, 0, 1'b0, 1'b0, 3'b000, h);
      if (h) run_halt(8'hFF);
      else begin
         miscompares++;
         $display("FAIL halt_word model did not reach halt");
      end

      for (int i = 0; i < 60; i++) begin
         op = 8'($urandom_range(0, 254));
         run_instr(op, -1, 0, 1'b0, 1'b0, 3'b000, h);
      end
      run_instr(8'hFF, -1, 0, 1'b0, 1'b0, 3'b000, h);
      if (h) run_halt(8'hFF);

      for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
      if (sbq.size() > 0) begin
         miscompares++;
         $display("FAIL drain pending=%0d required=0", sbq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/microcode_sequencer.md
Name: microcode_sequencer

Overview:
- Control unit that sits directly upstream of the memory stage.
- Consumes the instruction opcode latched by memory and steps through per-opcode microcode held in an external asynchronous ROM.
- Drives every memory-stage control strobe (PC, SP, instruction register, immediate and RAM bus drivers) plus auxiliary strobes for the ALU and register file.
- Owns the fetch/execute/halt state machine, the microstep counter, the latched condition flags, and conditional-jump qualification.

Parameters:
- STEP_WIDTH, 4, microstep counter width; 2^STEP_WIDTH steps max per instruction.
- AUX_WIDTH, 8, number of auxiliary control strobes passed through from microcode.

Ports:
- i_clk  in  1  system clock; all state changes on rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_instrCode  in  8  opcode from memory stage.
- i_flags  in  3  ALU flags {N,Z,C}.
- i_pause  in  1  high freezes sequencer.
- o_ucodeAddress  out  8+STEP_WIDTH  {i_instrCode, step} to microcode ROM.
- i_ucodeData  in  16+AUX_WIDTH  microcode word, async read.
- o_ctrlNotPCIncr  out  1  high increments PC.
- o_ctrlNotPCLoad  out  1  low loads PC from immediate.
- o_ctrlSpDirection  out  1  0 down, 1 up.
- o_ctrlNotSpEn  out  1  low steps SP.
- o_ctrlInstrNWE  out  1  low latches ROM word into instruction register.
- o_ctrlInstrImmNOE  out  1  low drives immediate onto bus.
- o_ctrlRamNOE  out  1  low drives RAM onto bus.
- o_ctrlRamNWE  out  1  low writes RAM.
- o_ctrlAux  out  AUX_WIDTH  active-high auxiliary strobes.
- o_halted  out  1  high in HALT.
- o_step  out  STEP_WIDTH  current microstep, for debug display.

Behaviour:
- Microcode word bits:
  - [0] pcIncr
  - [1] pcLoad
  - [2] spEn
  - [3] spDir
  - [4] immOE
  - [5] ramOE
  - [6] ramWE
  - [8:7] cond: 00 always, 01 C, 10 Z, 11 N
  - [9] condInvert
  - [10] flagsLatch
  - [11] last
  - [12] halt
  - [15:13] reserved, ignored
  - [16+:AUX_WIDTH] aux
- "Inactive" outputs: active-low strobes high; o_ctrlNotPCIncr low; o_ctrlSpDirection low; aux zero.
- States: FETCH, EXEC, HALT. Reset (i_reset low, asynchronous) forces state FETCH, step 0, flag register 0, o_halted 0.
- FETCH, one cycle:
  - o_ctrlInstrNWE low, o_ctrlNotPCIncr high, all other outputs inactive; i_ucodeData is ignored.
  - Next state EXEC, step 0.
- EXEC:
  - Outputs decoded combinationally from i_ucodeData. Strobes are inverted onto active-low ports; pcIncr drives o_ctrlNotPCIncr directly.
  - o_ctrlInstrNWE stays high.
  - Condition = selected latched flag XOR condInvert; cond=00 gives condition true (condInvert ignored).
  - pcLoad reaches o_ctrlNotPCLoad only when condition is true. No other strobe is qualified.
  - flagsLatch: flag register <= i_flags at the clock edge.
  - Next state:
    - halt set: HALT; halt has priority over last.
    - else last set, or step is all-ones: FETCH, step 0. Overflow forces fetch with no wrap.
    - else: step+1.
- HALT: all outputs inactive, o_halted high; exit only via reset.
- i_pause high:
  - No state, step or flag change.
  - All outputs inactive, except o_ucodeAddress, o_step and o_halted, which hold.
  - Sampled with the same edge as the state logic; release resumes the exact step.
- o_ucodeAddress = {i_instrCode, step} in every state.
- o_step = step register.
- Outputs are combinational from state, step, flags and ROM data, with zero added latency. Every instruction costs 1 fetch cycle plus N microsteps.
- Reset mid-instruction abandons the instruction; memory's own reset clears PC/SP.

Test Plan:
- Reset low then release, no pause → cycle 1: o_ctrlInstrNWE=0, o_ctrlNotPCIncr=1, state FETCH; cycle 2: EXEC step 0, o_ucodeAddress={opcode,0}.
- Opcode 0x12, ROM steps 0..2 words {immOE}, {ramWE}, {ramWE,last} → strobes follow in consecutive cycles, then FETCH on the 4th EXEC-relative cycle; o_step 0,1,2,0.
- Conditional jump, cond=10: flags latched Z=1 → o_ctrlNotPCLoad=0; Z=0 → stays 1; condInvert=1 with Z=0 → load asserted.
- Microcode without last for 16 steps → after step 15, FETCH follows; no step 16 or wrap.
- Word with halt and last set → HALT, o_halted=1, all strobes inactive for 20 cycles; reset low → FETCH.
- i_pause high for 5 cycles at step 2 of a multi-step opcode → outputs inactive, o_step=2 held; on release the step-2 word executes once. Async reset asserted mid-pause clears immediately.
